// File: rtl/tdm_demux_if.sv
// Bundles the TDM receiver's sample input, channel outputs and frame handshake.
// frame_cnt is present only when TDM_FRAME_CNT_EN is defined.
interface tdm_demux_if #(
  parameter int NCH = 4,
  parameter int DW  = 8
);
  logic              in_valid;
  logic [DW-1:0]     in_data;
  logic              in_sof;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_valid;
  logic [NCH*DW-1:0] frame_data;
  logic              frame_valid;
  logic              frame_ready;
  logic              locked;
  logic              sync_err;
  logic              overrun;
`ifdef TDM_FRAME_CNT_EN
  logic [15:0]       frame_cnt;
`endif

  modport master (
    output in_valid, in_data, in_sof, frame_ready,
    input  ch_data, ch_valid, frame_data, frame_valid, locked, sync_err, overrun
`ifdef TDM_FRAME_CNT_EN
    , input frame_cnt
`endif
  );

  modport slave (
    input  in_valid, in_data, in_sof, frame_ready,
    output ch_data, ch_valid, frame_data, frame_valid, locked, sync_err, overrun
`ifdef TDM_FRAME_CNT_EN
    , output frame_cnt
`endif
  );
endinterface

// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: routes slot-ordered samples to channel registers and
// assembles whole frames behind a valid/ready hold. Optional frame counter: TDM_FRAME_CNT_EN.
module tdm_demux #(
  parameter int NCH = 4,
  parameter int DW  = 8,
  parameter int CW  = 2
) (
  input  logic       clk,
  input  logic       rst,
  tdm_demux_if.slave bus
);
  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  localparam logic [CW-1:0] LAST_SLOT = CW'(NCH - 1);

  if ((2 ** CW) < NCH) begin : g_cw_check
    $error("tdm_demux: CW too narrow for NCH");
  end

  state_t            r_state, w_state_next;
  logic [CW-1:0]     r_slot, w_slot_next, w_wr_slot;
  logic              w_accept, w_sync_err, w_frame_done, w_frame_load;
  logic              w_frame_valid_next;
  logic [DW-1:0]     r_stage   [NCH];
  logic [DW-1:0]     r_ch_data [NCH];
  logic [NCH-1:0]    r_ch_valid, w_ch_valid_next;
  logic [NCH*DW-1:0] r_frame_data, w_frame_word;
  logic              r_frame_valid, r_sync_err, r_overrun;

  always_comb begin
    w_state_next = r_state;
    w_slot_next  = r_slot;
    w_wr_slot    = r_slot;
    w_accept     = 1'b0;
    w_sync_err   = 1'b0;
    if (bus.in_valid) begin
      unique case (r_state)
        HUNT: begin
          if (bus.in_sof) begin
            w_state_next = LOCK;
            w_accept     = 1'b1;
            w_wr_slot    = '0;
            w_slot_next  = CW'(1);
          end
        end
        LOCK: begin
          if (bus.in_sof) begin
            // An SOF mid-frame abandons the partial frame and restarts at slot 0.
            w_sync_err  = (r_slot != '0);
            w_accept    = 1'b1;
            w_wr_slot   = '0;
            w_slot_next = CW'(1);
          end else if (r_slot == '0) begin
            w_sync_err   = 1'b1;
            w_state_next = HUNT;
          end else begin
            w_accept    = 1'b1;
            w_slot_next = (r_slot == LAST_SLOT) ? '0 : r_slot + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_frame_done = w_accept && (w_wr_slot == LAST_SLOT);
  assign w_frame_load = w_frame_done && (!r_frame_valid || bus.frame_ready);

  always_comb begin
    w_frame_valid_next = r_frame_valid;
    if (r_frame_valid && bus.frame_ready) w_frame_valid_next = 1'b0;
    if (w_frame_load)                     w_frame_valid_next = 1'b1;
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
    // The last slot's sample is still on the input when the frame completes.
    if (gi == NCH - 1) begin : g_last
      assign w_frame_word[gi*DW +: DW] = bus.in_data;
    end else begin : g_mid
      assign w_frame_word[gi*DW +: DW] = r_stage[gi];
    end
    assign w_ch_valid_next[gi]     = w_accept && (w_wr_slot == CW'(gi));
    assign bus.ch_data[gi*DW +: DW] = r_ch_data[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= HUNT;
      r_slot        <= '0;
      r_ch_valid    <= '0;
      r_frame_data  <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      r_overrun     <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        r_stage[k]   <= '0;
        r_ch_data[k] <= '0;
      end
    end else begin
      r_state       <= w_state_next;
      r_slot        <= w_slot_next;
      r_ch_valid    <= w_ch_valid_next;
      r_frame_valid <= w_frame_valid_next;
      r_sync_err    <= w_sync_err;
      if (w_accept) begin
        r_stage[w_wr_slot]   <= bus.in_data;
        r_ch_data[w_wr_slot] <= bus.in_data;
      end
      if (w_frame_load) r_frame_data <= w_frame_word;
      if (w_frame_done && !w_frame_load) r_overrun <= 1'b1;
    end
  end

`ifdef TDM_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Counts every completed frame, dropped ones included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_frame_cnt <= '0;
    else if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  assign bus.frame_cnt = r_frame_cnt;
`endif

  assign bus.ch_valid    = r_ch_valid;
  assign bus.frame_data  = r_frame_data;
  assign bus.frame_valid = r_frame_valid;
  assign bus.locked      = (r_state == LOCK);
  assign bus.sync_err    = r_sync_err;
  assign bus.overrun     = r_overrun;
endmodule
